// File: rtl/garage_door_plant.sv
// Garage door plant model: integrates UP_M/DOWN_M into a bounded door position,
// decodes the limit switches, flags contradictory drive, and debounces the wall button.
module garage_door_plant #(
  parameter int TRAVEL_TICKS = 8,
  parameter int STEP_DIV     = 4,
  parameter int DEBOUNCE     = 3,
  parameter int POS_W        = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             UP_M,
  input  logic             DOWN_M,
  input  logic             BUTTON,
  output logic             Activate,
  output logic             UP_MAX,
  output logic             DOWN_MAX,
  output logic [POS_W-1:0] POSITION,
  output logic             FAULT
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE - 1);
  localparam logic [POS_W-1:0] POS_TOP   = POS_W'(TRAVEL_TICKS);
  localparam logic [POS_W-1:0] POS_TOP_M1 = POS_W'(TRAVEL_TICKS - 1);
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

  typedef enum logic [1:0] {STOPPED, RISING, FALLING, JAMMED} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   step_cnt_reg;
  logic [POS_W-1:0]   pos_reg;
  logic               fault_reg;

  logic               sync1_reg;
  logic               sync2_reg;
  logic               deb_level_reg;
  logic [DB_W-1:0]    deb_cnt_reg;
  logic               activate_reg;

  assign POSITION = pos_reg;
  assign FAULT    = fault_reg;
  assign Activate = activate_reg;
  assign UP_MAX   = (pos_reg == POS_TOP);
  assign DOWN_MAX = (pos_reg == '0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg    <= STOPPED;
      step_cnt_reg <= '0;
      pos_reg      <= '0;
      fault_reg    <= 1'b0;
    end else begin
      case (state_reg)
        STOPPED: begin
          step_cnt_reg <= '0;
          if (UP_M && DOWN_M) begin
            state_reg <= JAMMED;
            fault_reg <= 1'b1;
          end else if (UP_M && !UP_MAX) begin
            state_reg <= RISING;
          end else if (DOWN_M && !DOWN_MAX) begin
            state_reg <= FALLING;
          end
        end
        RISING: begin
          if (UP_M && DOWN_M) begin
            state_reg    <= JAMMED;
            fault_reg    <= 1'b1;
            step_cnt_reg <= '0;
          end else if (!UP_M) begin
            // Partial step is discarded on stop or reversal.
            state_reg    <= (DOWN_M && !DOWN_MAX) ? FALLING : STOPPED;
            step_cnt_reg <= '0;
          end else if (UP_MAX) begin
            state_reg    <= STOPPED;
            step_cnt_reg <= '0;
          end else if (step_cnt_reg == STEP_LAST) begin
            step_cnt_reg <= '0;
            pos_reg      <= pos_reg + POS_ONE;
            if (pos_reg == POS_TOP_M1) state_reg <= STOPPED;
          end else begin
            step_cnt_reg <= step_cnt_reg + 1'b1;
          end
        end
        FALLING: begin
          if (UP_M && DOWN_M) begin
            state_reg    <= JAMMED;
            fault_reg    <= 1'b1;
            step_cnt_reg <= '0;
          end else if (!DOWN_M) begin
            state_reg    <= (UP_M && !UP_MAX) ? RISING : STOPPED;
            step_cnt_reg <= '0;
          end else if (DOWN_MAX) begin
            state_reg    <= STOPPED;
            step_cnt_reg <= '0;
          end else if (step_cnt_reg == STEP_LAST) begin
            step_cnt_reg <= '0;
            pos_reg      <= pos_reg - POS_ONE;
            if (pos_reg == POS_ONE) state_reg <= STOPPED;
          end else begin
            step_cnt_reg <= step_cnt_reg + 1'b1;
          end
        end
        JAMMED: begin
          step_cnt_reg <= '0;
          if (!UP_M && !DOWN_M) begin
            state_reg <= STOPPED;
            fault_reg <= 1'b0;
          end
        end
        default: begin
          state_reg    <= STOPPED;
          step_cnt_reg <= '0;
          fault_reg    <= 1'b0;
        end
      endcase
    end
  end

  // Button: 2-flop synchronizer, stability counter, rising-edge pulse on the debounced level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      deb_level_reg <= 1'b0;
      deb_cnt_reg   <= '0;
      activate_reg  <= 1'b0;
    end else begin
      sync1_reg    <= BUTTON;
      sync2_reg    <= sync1_reg;
      activate_reg <= 1'b0;
      if (sync2_reg != deb_level_reg) begin
        if (deb_cnt_reg == DB_LAST) begin
          deb_level_reg <= sync2_reg;
          deb_cnt_reg   <= '0;
          activate_reg  <= sync2_reg;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
      end else begin
        deb_cnt_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_garage_door_plant.sv
// Scoreboard bench for garage_door_plant: stimulus pushes hand-computed expectations,
// a monitor pops one per clock edge and compares.
module tb_garage_door_plant;

  logic       CLK;
  logic       RST;
  logic       UP_M;
  logic       DOWN_M;
  logic       BUTTON;
  logic       Activate;
  logic       UP_MAX;
  logic       DOWN_MAX;
  logic [3:0] POSITION;
  logic       FAULT;

  typedef struct {
    string tag;
    int    pos;
    int    flt;
    int    act;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  garage_door_plant #(
    .TRAVEL_TICKS(8), .STEP_DIV(4), .DEBOUNCE(3), .POS_W(4)
  ) dut (
    .CLK(CLK), .RST(RST), .UP_M(UP_M), .DOWN_M(DOWN_M), .BUTTON(BUTTON),
    .Activate(Activate), .UP_MAX(UP_MAX), .DOWN_MAX(DOWN_MAX),
    .POSITION(POSITION), .FAULT(FAULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic check_all(input string tag, input int pos, input int flt, input int act);
    check({tag, ".POSITION"}, int'(POSITION), pos);
    check({tag, ".UP_MAX"},   int'(UP_MAX),   (pos == 8) ? 1 : 0);
    check({tag, ".DOWN_MAX"}, int'(DOWN_MAX), (pos == 0) ? 1 : 0);
    check({tag, ".FAULT"},    int'(FAULT),    flt);
    check({tag, ".Activate"}, int'(Activate), act);
  endtask

  // Inputs change on the falling edge; the expectation is for the next rising edge.
  task automatic drive(input logic up, input logic dn, input logic btn,
                       input int pos, input int flt, input int act, input string tag);
    exp_t e;
    @(negedge CLK);
    UP_M   = up;
    DOWN_M = dn;
    BUTTON = btn;
    e.tag = tag; e.pos = pos; e.flt = flt; e.act = act;
    sb.push_back(e);
  endtask

  always @(posedge CLK) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      $display("tx %-8s up=%0b dn=%0b btn=%0b pos=%0d umax=%0b dmax=%0b flt=%0b act=%0b",
               mon_e.tag, UP_M, DOWN_M, BUTTON, POSITION, UP_MAX, DOWN_MAX, FAULT, Activate);
      check_all(mon_e.tag, mon_e.pos, mon_e.flt, mon_e.act);
    end
  end

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  initial begin
    RST = 1'b0; UP_M = 1'b0; DOWN_M = 1'b0; BUTTON = 1'b0;
    #1;
    check_all("rst_hold", 0, 0, 0);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 0, 0, "idle");
    // Full opening, then UP_M kept on against the top limit.
    for (int i = 0; i < 36; i++) drive(1, 0, 0, min_i(8, i / 4), 0, 0, "open");
    for (int i = 0; i < 36; i++) drive(0, 1, 0, 8 - min_i(8, i / 4), 0, 0, "close");
    // Open to 5 mid-step, pause, then close all the way.
    for (int i = 0; i < 23; i++) drive(1, 0, 0, min_i(8, i / 4), 0, 0, "open5");
    for (int i = 0; i < 3; i++)  drive(0, 0, 0, 5, 0, 0, "pause");
    for (int i = 0; i < 24; i++) drive(0, 1, 0, 5 - min_i(5, i / 4), 0, 0, "close5");
    // Jam while rising at 3; single command keeps it jammed, 00 releases.
    for (int i = 0; i < 14; i++) drive(1, 0, 0, i / 4, 0, 0, "open3");
    for (int i = 0; i < 3; i++)  drive(1, 1, 0, 3, 1, 0, "jam");
    drive(1, 0, 0, 3, 1, 0, "jam_up");
    drive(0, 0, 0, 3, 0, 0, "unjam");
    for (int i = 0; i < 7; i++)  drive(1, 0, 0, 3 + i / 4, 0, 0, "reopen");
    for (int i = 0; i < 12; i++) drive(0, 1, 0, 4 - i / 4, 0, 0, "reverse");
    drive(0, 0, 0, 2, 0, 0, "halt");
    // Button bounce, hold, release, then a press concurrent with motion.
    for (int i = 0; i < 10; i++) drive(0, 0, (i % 2 == 0), 2, 0, 0, "bounce");
    for (int j = 0; j < 12; j++) drive(0, 0, 1, 2, 0, (j == 4) ? 1 : 0, "hold");
    for (int j = 0; j < 10; j++) drive(0, 0, 0, 2, 0, 0, "release");
    for (int j = 0; j < 10; j++) drive(0, 1, 1, 2 - min_i(2, j / 4), 0, (j == 4) ? 1 : 0, "press_mv");
    for (int j = 0; j < 10; j++) drive(0, 0, 0, 0, 0, 0, "release2");
    // Rise to 6, reverse, then asynchronous reset while falling.
    for (int i = 0; i < 26; i++) drive(1, 0, 0, min_i(8, i / 4), 0, 0, "open6");
    for (int i = 0; i < 2; i++)  drive(0, 1, 0, 6, 0, 0, "fall6");
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 0, "post_rst");
    @(posedge CLK);
    #3;
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
